// File: rtl/dmp_pipe_checker.sv
// rtl/dmp_pipe_checker.sv - registered, handshaked PMP+DMP access checker with sticky fault capture
//
// Purpose:
//   Checks one physical access per cycle against NR_ENTRIES PMP entries.
//   Each entry may be OFF, TOR, NA4 or NAPOT, and the lowest-index match wins.
//   The PMP result is then qualified by a domain (DMP) ownership rule
//   against a per-core current-domain register.
//   The result is registered behind a one-deep valid/ready stage.
//   The first denied result is captured until it is cleared.
//   A saturating counter tracks denied results.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   request handshake
//   req_addr_i                physical address
//   req_access_i              one-hot access (R=1, W=2, X=4)
//   req_priv_i                requester privilege (3 = M)
//   conf_addr_i               packed pmpaddr per entry
//   pmpconf_i                 packed pmpcfg per entry {L, 2'b0, A[1:0], X, W, R}
//   dmpconf_i                 packed owner domain per entry
//   dom_set_valid_i/dom_set_i load current domain
//   curdom_o                  current domain
//   resp_valid_o/resp_ready_i result handshake
//   resp_allow_o, resp_idx_o  result and matching entry (0 when none)
//   fault_valid_o             sticky denial capture flag
//   fault_addr_o              address of the captured denial
//   fault_info_o              {access, domain} of the captured denial
//   fault_clr_i               clears the capture flag
//   deny_cnt_o                saturating count of denied results
module dmp_pipe_checker #(
   parameter int unsigned PLEN       = 56,
   parameter int unsigned PMP_LEN    = 54,
   parameter int unsigned NR_ENTRIES = 16,
   parameter int unsigned NR_DOMAINS = 4,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned DOM_W      = (NR_DOMAINS > 1) ? $clog2(NR_DOMAINS) : 1,
   parameter int unsigned IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic [PLEN-1:0]               req_addr_i,
   input  logic [2:0]                    req_access_i,
   input  logic [1:0]                    req_priv_i,
   input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
   input  logic [NR_ENTRIES*8-1:0]       pmpconf_i,
   input  logic [NR_ENTRIES*DOM_W-1:0]   dmpconf_i,
   input  logic                          dom_set_valid_i,
   input  logic [DOM_W-1:0]              dom_set_i,
   output logic [DOM_W-1:0]              curdom_o,
   output logic                          resp_valid_o,
   input  logic                          resp_ready_i,
   output logic                          resp_allow_o,
   output logic [IDX_W-1:0]              resp_idx_o,
   output logic                          fault_valid_o,
   output logic [PLEN-1:0]               fault_addr_o,
   output logic [3+DOM_W-1:0]            fault_info_o,
   input  logic                          fault_clr_i,
   output logic [CNT_W-1:0]              deny_cnt_o
);

   localparam logic [DOM_W-1:0] DOMI     = '1;
   localparam logic [1:0]       A_TOR    = 2'd1;
   localparam logic [1:0]       A_NA4    = 2'd2;
   localparam logic [1:0]       A_NAPOT  = 2'd3;
   localparam logic [1:0]       PRIV_M   = 2'd3;

   logic [DOM_W-1:0]   r_curdom;
   logic               r_resp_valid;
   logic               r_allow;
   logic [IDX_W-1:0]   r_idx;
   logic               r_fault_valid;
   logic [PLEN-1:0]    r_fault_addr;
   logic [3+DOM_W-1:0] r_fault_info;
   logic [CNT_W-1:0]   r_deny_cnt;

   logic [PMP_LEN-1:0]    w_wa;
   logic [NR_ENTRIES-1:0] w_hit;
   logic                  w_found;
   logic [IDX_W-1:0]      w_idx;
   logic [7:0]            w_cfg;
   logic [DOM_W-1:0]      w_dmp;
   logic                  w_pmp_ok;
   logic                  w_dmp_ok;
   logic                  w_allow;
   logic                  w_accept;

   assign w_wa = req_addr_i[PLEN-1:2];

   genvar g;
   for (g = 0; g < NR_ENTRIES; g++) begin : g_entry
      logic [PMP_LEN-1:0] w_conf;
      logic [PMP_LEN-1:0] w_lo;
      logic [PMP_LEN-1:0] w_mask;
      logic [1:0]         w_mode;

      assign w_conf = conf_addr_i[g*PMP_LEN +: PMP_LEN];
      assign w_mode = pmpconf_i[g*8+3 +: 2];

      if (g == 0) begin : g_lo0
         assign w_lo = '0;
      end else begin : g_lon
         assign w_lo = conf_addr_i[(g-1)*PMP_LEN +: PMP_LEN];
      end

      // conf ^ (conf+1) sets the trailing ones plus the following zero,
      // which is exactly the NAPOT don't-care region in word units.
      assign w_mask = w_conf ^ (w_conf + PMP_LEN'(1));

      assign w_hit[g] = (w_mode == A_TOR)   ? ((w_wa >= w_lo) && (w_wa < w_conf)) :
                        (w_mode == A_NA4)   ? (w_wa == w_conf) :
                        (w_mode == A_NAPOT) ? (((w_wa ^ w_conf) & ~w_mask) == '0) :
                                              1'b0;
   end

   // Scan from the top so the lowest matching index is the last one written.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
      w_cfg   = '0;
      w_dmp   = '0;
      for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(i);
            w_cfg   = pmpconf_i[i*8 +: 8];
            w_dmp   = dmpconf_i[i*DOM_W +: DOM_W];
         end
      end
   end

   assign w_pmp_ok = (w_cfg[2:0] & req_access_i) == req_access_i;
   assign w_dmp_ok = (r_curdom == DOMI) || (w_dmp == DOMI) || (w_dmp == r_curdom);

   always_comb begin
      w_allow = 1'b0;
      if (!w_found) begin
         w_allow = (req_priv_i == PRIV_M);
      end else if (req_priv_i == PRIV_M) begin
         // M-mode is only constrained by locked entries and ignores domains.
         w_allow = !w_cfg[7] || w_pmp_ok;
      end else begin
         w_allow = w_pmp_ok && w_dmp_ok;
      end
   end

   assign req_ready_o = !r_resp_valid || resp_ready_i;
   assign w_accept    = req_valid_i && req_ready_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_curdom      <= DOMI;
         r_resp_valid  <= 1'b0;
         r_allow       <= 1'b0;
         r_idx         <= '0;
         r_fault_valid <= 1'b0;
         r_fault_addr  <= '0;
         r_fault_info  <= '0;
         r_deny_cnt    <= '0;
      end else begin
         if (dom_set_valid_i) begin
            r_curdom <= dom_set_i;
         end

         if (w_accept) begin
            r_resp_valid <= 1'b1;
            r_allow      <= w_allow;
            r_idx        <= w_idx;
         end else if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
         end

         // Denials are accounted at the edge that loads the beat, so a
         // stalled beat is never counted or captured twice.
         if (w_accept && !w_allow && (!r_fault_valid || fault_clr_i)) begin
            r_fault_valid <= 1'b1;
            r_fault_addr  <= req_addr_i;
            r_fault_info  <= {req_access_i, r_curdom};
         end else if (fault_clr_i) begin
            r_fault_valid <= 1'b0;
         end

         if (w_accept && !w_allow && (r_deny_cnt != '1)) begin
            r_deny_cnt <= r_deny_cnt + CNT_W'(1);
         end
      end
   end

   assign curdom_o      = r_curdom;
   assign resp_valid_o  = r_resp_valid;
   assign resp_allow_o  = r_allow;
   assign resp_idx_o    = r_idx;
   assign fault_valid_o = r_fault_valid;
   assign fault_addr_o  = r_fault_addr;
   assign fault_info_o  = r_fault_info;
   assign deny_cnt_o    = r_deny_cnt;

endmodule
